// File: rtl/ssdm_pkg.sv
// rtl/ssdm_pkg.sv - shared constants for the seven-segment scan display
// Holds the hex segment table (active-low, {g,f,e,d,c,b,a}), the all-off
// codes for segments and anodes, and the number of scanned digits.
package ssdm_pkg;

  localparam int DIGITS = 4;

  typedef logic [3:0] hex_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  localparam seg_t SEG_HEX [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/ssd_dec.sv
// rtl/ssd_dec.sv - combinational hex to seven-segment decoder
// Ports:
//   hex : 4-bit hex digit in
//   seg : 7-bit active-low segment pattern {g,f,e,d,c,b,a}
module ssd_dec
  import ssdm_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[hex];

endmodule

// File: rtl/ssdm_scan.sv
// rtl/ssdm_scan.sv - four-digit multiplexed seven-segment display scanner
// Ports:
//   ssdm_clk : clock
//   ssdm_rst : synchronous active-high reset
//   ssdm_d   : hex value pushed into the history on ssdm_ld
//   ssdm_ld  : one-cycle push strobe (held high = one push per cycle)
//   ssdm_lzb : leading-zero blanking enable
//   ssdm_seg : registered segments, active-low {g,f,e,d,c,b,a}
//   ssdm_dp  : registered decimal point, active-low (lit on digit 0)
//   ssdm_an  : registered anodes, active-low, one-hot-low when driven
module ssdm_scan
  import ssdm_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic       ssdm_clk,
  input  logic       ssdm_rst,
  input  logic [3:0] ssdm_d,
  input  logic       ssdm_ld,
  input  logic       ssdm_lzb,
  output logic [6:0] ssdm_seg,
  output logic       ssdm_dp,
  output logic [3:0] ssdm_an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0]     cnt;
  logic [1:0]        idx;
  logic [3:0]        hist [DIGITS];
  logic [DIGITS-1:0] vld;

  logic              wrap;
  logic              in_blank;
  logic [3:0]        cur_hex;
  logic              cur_vld;
  logic [6:0]        dec_seg;
  logic [DIGITS-1:0] lz_mask;
  logic              zero_above;
  logic [6:0]        seg_n;
  logic [3:0]        an_n;
  logic              dp_n;

  assign wrap     = (cnt == CNT_LAST);
  assign in_blank = (cnt < CNT_BLANK);
  assign cur_hex  = hist[idx];
  assign cur_vld  = vld[idx];

  ssd_dec u_dec (
    .hex (cur_hex),
    .seg (dec_seg)
  );

  // Walk from the most significant digit down: a digit is a leading zero
  // when it is zero and every valid digit above it is zero too. Invalid
  // digits above do not stop the run since they display nothing anyway.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lz_mask[k] = ssdm_lzb && (hist[k] == 4'd0) && zero_above;
      zero_above = zero_above && (!vld[k] || (hist[k] == 4'd0));
    end
  end

  // Next pin values from the current counter/history state; registered
  // below so all three pin groups move on the same edge.
  always_comb begin
    seg_n = SEG_OFF;
    an_n  = AN_OFF;
    dp_n  = 1'b1;
    if (!in_blank) begin
      an_n = ~(4'b0001 << idx);
      if (cur_vld && !lz_mask[idx]) begin
        seg_n = dec_seg;
      end
      dp_n = !((idx == 2'd0) && vld[0]);
    end
  end

  always_ff @(posedge ssdm_clk) begin
    if (ssdm_rst) begin
      cnt      <= '0;
      idx      <= 2'd0;
      vld      <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        hist[i] <= 4'd0;
      end
      ssdm_seg <= SEG_OFF;
      ssdm_an  <= AN_OFF;
      ssdm_dp  <= 1'b1;
    end else begin
      if (wrap) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      // A push on the wrap cycle lands together with the index change, so
      // the newly selected digit is decoded from the shifted history.
      if (ssdm_ld) begin
        for (int i = DIGITS - 1; i >= 1; i--) begin
          hist[i] <= hist[i-1];
        end
        hist[0] <= ssdm_d;
        vld     <= {vld[DIGITS-2:0], 1'b1};
      end

      ssdm_seg <= seg_n;
      ssdm_an  <= an_n;
      ssdm_dp  <= dp_n;
    end
  end

endmodule

// File: tb/tb_ssdm_scan.sv
// tb/tb_ssdm_scan.sv - directed self-checking bench for ssdm_scan
module tb_ssdm_scan;

  logic       clk;
  logic       rst;
  logic [3:0] d;
  logic       ld;
  logic       lzb;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int vec;
  int errs;
  int pos;

  ssdm_scan #(
    .REFRESH_DIV (8),
    .BLANK_CYC   (2)
  ) dut (
    .ssdm_clk (clk),
    .ssdm_rst (rst),
    .ssdm_d   (d),
    .ssdm_ld  (ld),
    .ssdm_lzb (lzb),
    .ssdm_seg (seg),
    .ssdm_dp  (dp),
    .ssdm_an  (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pos counts rising edges since the reset edge; the pins after edge pos
  // show the scan state counter=(pos-1)%8, digit=((pos-1)/8)%4.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    pos += n;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ld  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
  endtask

  // Advance to the first sample where digit dg is driven.
  task automatic goto_digit(input int dg);
    step(1);
    while (((pos - 1) % 32) != (8 * dg + 2)) step(1);
  endtask

  task automatic load(input logic [3:0] v);
    d  = v;
    ld = 1'b1;
    step(1);
    ld = 1'b0;
    d  = 4'hE;
  endtask

  task automatic test_reset();
    int         cp [7] = '{1, 2, 3, 11, 19, 27, 35};
    logic [3:0] ea [7] = '{4'b1111, 4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    do_reset();
    vec++;
    if (seg !== 7'b1111111 || an !== 4'b1111 || dp !== 1'b1) begin
      errs++;
      $display("FAIL reset_state: seg=%b an=%b dp=%b want 1111111 1111 1", seg, an, dp);
    end
    for (int i = 0; i < 7; i++) begin
      step(cp[i] - pos);
      vec++;
      if (an !== ea[i] || seg !== 7'b1111111 || dp !== 1'b1) begin
        errs++;
        $display("FAIL idle_scan edge%0d: an=%b seg=%b dp=%b want an=%b seg=1111111 dp=1",
                 cp[i], an, seg, dp, ea[i]);
      end
    end
  endtask

  task automatic test_two_loads();
    logic [6:0] es [4] = '{7'b0001000, 7'b0110000, 7'b1111111, 7'b1111111};
    logic [3:0] ea;
    logic       edp;
    do_reset();
    lzb = 1'b0;
    load(4'h3);
    load(4'hA);
    for (int dg = 0; dg < 4; dg++) begin
      goto_digit(dg);
      ea  = ~(4'b0001 << dg);
      edp = (dg == 0) ? 1'b0 : 1'b1;
      vec++;
      if (seg !== es[dg] || an !== ea || dp !== edp) begin
        errs++;
        $display("FAIL two_loads digit%0d: seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                 dg, seg, an, dp, es[dg], ea, edp);
      end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] es1 [4] = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
    logic [6:0] es0 [4] = '{7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000};
    logic [3:0] ea;
    do_reset();
    lzb = 1'b1;
    load(4'h0);
    load(4'h0);
    load(4'h5);
    load(4'h0);
    for (int dg = 0; dg < 4; dg++) begin
      goto_digit(dg);
      ea = ~(4'b0001 << dg);
      vec++;
      if (seg !== es1[dg] || an !== ea) begin
        errs++;
        $display("FAIL lzb_on digit%0d: seg=%b an=%b want seg=%b an=%b", dg, seg, an, es1[dg], ea);
      end
    end
    lzb = 1'b0;
    for (int dg = 0; dg < 4; dg++) begin
      goto_digit(dg);
      vec++;
      if (seg !== es0[dg]) begin
        errs++;
        $display("FAIL lzb_off digit%0d: seg=%b want %b", dg, seg, es0[dg]);
      end
    end
  endtask

  task automatic test_wrap_load();
    do_reset();
    lzb = 1'b0;
    load(4'h1);
    step(31 - pos);
    d  = 4'h9;
    ld = 1'b1;
    step(1);
    ld = 1'b0;
    d  = 4'h0;
    vec++;
    if (an !== 4'b0111) begin
      errs++;
      $display("FAIL wrap_last_digit3: an=%b want 0111", an);
    end
    step(1);
    vec++;
    if (an !== 4'b1111 || seg !== 7'b1111111) begin
      errs++;
      $display("FAIL wrap_blank1: an=%b seg=%b want 1111 1111111", an, seg);
    end
    step(1);
    vec++;
    if (an !== 4'b1111) begin
      errs++;
      $display("FAIL wrap_blank2: an=%b want 1111", an);
    end
    step(1);
    vec++;
    if (an !== 4'b1110 || seg !== 7'b0010000 || dp !== 1'b0) begin
      errs++;
      $display("FAIL wrap_new_digit0: an=%b seg=%b dp=%b want 1110 0010000 0", an, seg, dp);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lzb = 1'b0;
    load(4'h1);
    load(4'h2);
    load(4'h3);
    goto_digit(2);
    step(2);
    vec++;
    if (an !== 4'b1011 || seg !== 7'b1111001) begin
      errs++;
      $display("FAIL pre_reset_digit2: an=%b seg=%b want 1011 1111001", an, seg);
    end
    rst = 1'b1;
    ld  = 1'b1;
    d   = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    ld  = 1'b0;
    pos = 0;
    vec++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      errs++;
      $display("FAIL mid_reset_off: an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
    end
    goto_digit(0);
    vec++;
    if (pos !== 3 || an !== 4'b1110 || seg !== 7'b1111111 || dp !== 1'b1) begin
      errs++;
      $display("FAIL mid_reset_digit0: edge=%0d an=%b seg=%b dp=%b want edge=3 1110 1111111 1",
               pos, an, seg, dp);
    end
    goto_digit(1);
    vec++;
    if (an !== 4'b1101 || seg !== 7'b1111111) begin
      errs++;
      $display("FAIL mid_reset_digit1: an=%b seg=%b want 1101 1111111", an, seg);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] es [4] = '{7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100};
    do_reset();
    lzb = 1'b0;
    for (int i = 1; i <= 5; i++) load(4'(i));
    for (int dg = 0; dg < 4; dg++) begin
      goto_digit(dg);
      vec++;
      if (seg !== es[dg]) begin
        errs++;
        $display("FAIL overflow digit%0d: seg=%b want %b", dg, seg, es[dg]);
      end
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    pos  = 0;
    rst  = 1'b1;
    ld   = 1'b0;
    d    = 4'h0;
    lzb  = 1'b0;
    @(negedge clk);
    test_reset();
    test_two_loads();
    test_lzb();
    test_wrap_load();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
